bin2bcd_seq: RTL and testbench



---
 rtl/io_pkg.sv | 19 +
 rtl/bcd_add3_nibble.sv | 12 +
 rtl/bin2bcd_seq.sv | 128 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
package io_pkg;

    // Default converter geometry: 14 bits covers 0..16383, enough for 9999.
    localparam int unsigned BIN_W_DEF   = 14;
    localparam int unsigned DIGITS_DEF  = 4;
    localparam int unsigned MAX_VAL_DEF = 9999;

    // Display stage renders this digit code as all segments off.
    localparam logic [3:0]  BCD_BLANK = 4'hF;
    localparam logic [15:0] BCD_MAX   = 16'h9999;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/bcd_add3_nibble.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_add3_nibble (
    input  logic [3:0] nibble_i,
    output logic [3:0] nibble_o
);

    // Input is always 0..9 here, so the add never wraps.
    always_comb begin
        nibble_o = (nibble_i >= 4'd5) ? nibble_i + 4'd3 : nibble_i;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble) feeding the 4-digit display.
// Optional build macro BIN2BCD_LZ_BLANK_EN: replace leading zero digits with the
// blank code when the result is registered (units digit is never blanked).
module bin2bcd_seq
    import io_pkg::*;
#(
    parameter int unsigned BIN_W   = BIN_W_DEF,
    parameter int unsigned DIGITS  = DIGITS_DEF,
    parameter int unsigned MAX_VAL = MAX_VAL_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bin_valid_i,
    input  logic [BIN_W-1:0]      bin_data_i,
    output logic                  bin_ready_o,
    output logic [4*DIGITS-1:0]   seg_8421_code_o,
    output logic                  code_update_o
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_e             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   code_q, code_d;
    logic               upd_q, upd_d;

    logic [BIN_W-1:0]   bin_sat;
    logic [BCD_W-1:0]   bcd_adj;
    logic [SR_W-1:0]    sr_shift;
    logic [BCD_W-1:0]   bcd_res;
    logic [BCD_W-1:0]   bcd_out;

    assign bin_ready_o     = (state_q == StIdle);
    assign seg_8421_code_o = code_q;
    assign code_update_o   = upd_q;

    // Clamp out-of-range inputs so the result saturates at all nines.
    always_comb begin
        bin_sat = (bin_data_i > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : bin_data_i;
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_add3_nibble u_add3 (
            .nibble_i (sr_q[BIN_W + 4*d +: 4]),
            .nibble_o (bcd_adj[4*d +: 4])
        );
    end

    assign sr_shift = {bcd_adj[BCD_W-2:0], sr_q[BIN_W-1:0], 1'b0};
    assign bcd_res  = sr_q[SR_W-1:BIN_W];

`ifdef BIN2BCD_LZ_BLANK_EN
    // Blank leading zero digits from the most significant end; units always shown.
    always_comb begin
        logic lead;
        bcd_out = bcd_res;
        lead    = 1'b1;
        for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
            if (lead && (bcd_res[4*d +: 4] == 4'd0)) begin
                bcd_out[4*d +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    // Digits pass through unchanged, leading zeros included.
    always_comb begin
        bcd_out = bcd_res;
    end
`endif

    // Next-state and datapath control for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        upd_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bin_valid_i) begin
                    sr_d    = {{BCD_W{1'b0}}, bin_sat};
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                // Iterations run at counts 0..BIN_W-1; the count BIN_W cycle only
                // hands over to DONE, giving a fixed BIN_W+2 accept-to-update latency.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W)) begin
                    cnt_d   = cnt_q;
                    state_d = StDone;
                end else begin
                    sr_d = sr_shift;
                end
            end
            StDone: begin
                code_d  = bcd_out;
                upd_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset discards any in-flight conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            upd_q   <= upd_d;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (both blanking builds).
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        bin_valid;
    logic [13:0] bin_data;
    logic        bin_ready;
    logic [15:0] seg_code;
    logic        code_update;

    int checks = 0;
    int errors = 0;

`ifdef BIN2BCD_LZ_BLANK_EN
    localparam logic [15:0] EXP_0    = 16'hFFF0;
    localparam logic [15:0] EXP_42   = 16'hFF42;
    localparam logic [15:0] EXP_7    = 16'hFFF7;
    localparam logic [15:0] EXP_500  = 16'hF500;
    localparam logic [15:0] EXP_600  = 16'hF600;
    localparam logic [15:0] EXP_31   = 16'hFF31;
`else
    localparam logic [15:0] EXP_0    = 16'h0000;
    localparam logic [15:0] EXP_42   = 16'h0042;
    localparam logic [15:0] EXP_7    = 16'h0007;
    localparam logic [15:0] EXP_500  = 16'h0500;
    localparam logic [15:0] EXP_600  = 16'h0600;
    localparam logic [15:0] EXP_31   = 16'h0031;
`endif

    bin2bcd_seq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bin_valid_i     (bin_valid),
        .bin_data_i      (bin_data),
        .bin_ready_o     (bin_ready),
        .seg_8421_code_o (seg_code),
        .code_update_o   (code_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Accept one value, then follow it edge by edge up to its update edge.
    task automatic convert(input logic [13:0] val, input logic [15:0] exp, input string tag);
        logic [15:0] prev;
        prev = seg_code;
        @(negedge clk);
        chk({tag, "_ready_pre"}, {15'd0, bin_ready}, 16'd1);
        bin_valid = 1'b1;
        bin_data  = val;
        @(posedge clk);
        #1;
        bin_valid = 1'b0;
        bin_data  = 14'h2AAA;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k < 16) begin
                chk({tag, "_ready_busy"}, {15'd0, bin_ready}, 16'd0);
                chk({tag, "_upd_idle"}, {15'd0, code_update}, 16'd0);
                chk({tag, "_hold"}, seg_code, prev);
            end else begin
                chk({tag, "_upd"}, {15'd0, code_update}, 16'd1);
                chk({tag, "_code"}, seg_code, exp);
                chk({tag, "_ready_back"}, {15'd0, bin_ready}, 16'd1);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_upd_drop"}, {15'd0, code_update}, 16'd0);
        chk({tag, "_code_hold"}, seg_code, exp);
    endtask

    initial begin
        int pulses;
        rst_n     = 1'b0;
        bin_valid = 1'b0;
        bin_data  = '0;
        #2;
        chk("rst_ready", {15'd0, bin_ready}, 16'd1);
        chk("rst_code", seg_code, 16'h0000);
        chk("rst_upd", {15'd0, code_update}, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {15'd0, bin_ready}, 16'd1);

        convert(14'd0,     EXP_0,     "v0");
        convert(14'd1234,  16'h1234,  "v1234");
        convert(14'd9999,  16'h9999,  "v9999");
        convert(14'd12000, 16'h9999,  "v12000");
        convert(14'd16383, 16'h9999,  "v16383");
        convert(14'd42,    EXP_42,    "v42");
        convert(14'd7,     EXP_7,     "v7");
        convert(14'd1005,  16'h1005,  "v1005");

        // Valid held across a busy period: second value waits for ready.
        @(negedge clk);
        bin_valid = 1'b1;
        bin_data  = 14'd500;
        @(posedge clk);
        #1;
        bin_data = 14'd600;
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            #1;
            if (k == 16) begin
                chk("hold_500_upd", {15'd0, code_update}, 16'd1);
                chk("hold_500_code", seg_code, EXP_500);
            end
            if (k == 17) begin
                chk("hold_600_accepted", {15'd0, bin_ready}, 16'd0);
                bin_valid = 1'b0;
            end
            if (k == 32) chk("hold_600_early", {15'd0, code_update}, 16'd0);
            if (k == 33) begin
                chk("hold_600_upd", {15'd0, code_update}, 16'd1);
                chk("hold_600_code", seg_code, EXP_600);
            end
        end

        // Reset in the middle of a conversion.
        @(negedge clk);
        bin_valid = 1'b1;
        bin_data  = 14'd8765;
        @(posedge clk);
        #1;
        bin_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_code", seg_code, 16'h0000);
        chk("midrst_ready", {15'd0, bin_ready}, 16'd1);
        chk("midrst_upd", {15'd0, code_update}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (code_update) pulses++;
        end
        chk("midrst_no_pulse", 16'(pulses), 16'd0);
        chk("midrst_code_after", seg_code, 16'h0000);
        chk("midrst_ready_after", {15'd0, bin_ready}, 16'd1);
        convert(14'd31, EXP_31, "v31");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
